// File: rtl/piso_tx_en_if.sv
// piso_tx_en_if: word/serial handshake bundle between a producer and the PISO transmitter.
interface piso_tx_en_if #(parameter int WIDTH = 8);
   logic             load;
   logic [WIDTH-1:0] din;
   logic             enable;
   logic             ready;
   logic             sout;
   logic             sout_valid;
   logic             done;
   modport master (output load, din, enable, input ready, sout, sout_valid, done);
   modport slave (input load, din, enable, output ready, sout, sout_valid, done);
endinterface

// File: rtl/piso_tx_en.sv
// piso_tx_en: parallel-in serial-out transmitter, MSB first, one bit per enabled clock.
module piso_tx_en #(parameter int WIDTH = 8) (
   input logic         clock,
   input logic         reset_n,
   piso_tx_en_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state          <= IDLE;
         shreg          <= '0;
         cnt            <= '0;
         bus.sout       <= 1'b0;
         bus.sout_valid <= 1'b0;
         bus.done       <= 1'b0;
         bus.ready      <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               bus.done       <= 1'b0;
               bus.sout_valid <= 1'b0;
               bus.sout       <= 1'b0;
               bus.ready      <= !bus.load;
               if (bus.load) begin
                  shreg <= bus.din;
                  cnt   <= CW'(WIDTH);
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               // a stall keeps sout at its last bit but marks it stale
               bus.sout_valid <= bus.enable;
               if (bus.enable && cnt != '0) begin
                  bus.sout <= shreg[WIDTH-1];
                  shreg    <= shreg << 1;
                  cnt      <= cnt - 1'b1;
                  if (cnt == CW'(1)) state <= DONE;
               end
            end
            DONE: begin
               bus.done       <= 1'b1;
               bus.sout_valid <= 1'b0;
               bus.sout       <= 1'b0;
               bus.ready      <= 1'b1;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_piso_tx_en.sv
// tb_piso_tx_en: directed and random stimulus against a queue-based model of the transmitter.
module tb_piso_tx_en;
   localparam int W = 8;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   piso_tx_en_if #(W) bus();
   piso_tx_en #(.WIDTH(W)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
   always #5 clock = ~clock;
   int total = 0, passed = 0, fails = 0;
   bit m_rdy = 1, m_sout = 0, m_vld = 0, m_done = 0;
   int phase = 0;
   bit q[$];
   logic [W-1:0] word_in = '0, got = '0;
   int nbits = 0;
   task automatic chk(string tag, logic obs, logic exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask
   // phase: 0 idle, 1 bits pending, 2 last bit shown and done due next edge
   task automatic step(bit rn, bit ld, logic [W-1:0] d, bit en);
      reset_n = rn;
      bus.load = ld;
      bus.din = d;
      bus.enable = en;
      @(posedge clock);
      if (!rn) begin
         q.delete();
         phase = 0; m_rdy = 1; m_sout = 0; m_vld = 0; m_done = 0;
      end else if (phase == 0) begin
         m_done = 0; m_vld = 0; m_sout = 0; m_rdy = !ld;
         if (ld) begin
            for (int i = W - 1; i >= 0; i--) q.push_back(d[i]);
            word_in = d;
            phase = 1;
         end
      end else if (phase == 1) begin
         m_vld = en;
         if (en) begin
            m_sout = q.pop_front();
            if (q.size() == 0) phase = 2;
         end
      end else begin
         m_done = 1; m_vld = 0; m_sout = 0; m_rdy = 1; phase = 0;
      end
      #1;
      chk("ready", bus.ready, m_rdy);
      chk("sout", bus.sout, m_sout);
      chk("sout_valid", bus.sout_valid, m_vld);
      chk("done", bus.done, m_done);
      if (!rn) nbits = 0;
      if (bus.sout_valid) begin
         got = {got[W-2:0], bus.sout};
         nbits++;
      end
      if (bus.done) begin
         total++;
         assert (nbits == W && got === word_in) passed++;
         else begin
            fails++;
            $error("FAIL word observed=%h/%0d bits expected=%h/%0d bits", got, nbits, word_in, W);
         end
         nbits = 0;
      end
   endtask
   initial begin
      bit pat[7];
      pat = '{1, 0, 0, 1, 1, 0, 1};
      bus.load = 0; bus.din = '0; bus.enable = 0;
      step(0, 0, 8'h00, 0);
      step(0, 1, 8'hFF, 1);
      for (int i = 0; i < 4; i++) step(1, 0, 8'h00, i[0]);
      step(1, 1, 8'hA5, 1);
      for (int i = 0; i < 11; i++) step(1, 0, 8'h00, 1);
      step(1, 1, 8'hC3, 1);
      for (int i = 0; i < 18; i++) step(1, 0, 8'h00, pat[i % 7]);
      step(1, 1, 8'hF0, 1);
      for (int i = 0; i < 12; i++) step(1, i == 3, 8'h0F, 1);
      step(1, 1, 8'hFF, 1);
      for (int i = 0; i < 3; i++) step(1, 0, 8'h00, 1);
      step(0, 1, 8'h55, 1);
      step(1, 1, 8'h81, 1);
      for (int i = 0; i < 11; i++) step(1, 0, 8'h00, 1);
      step(1, 1, 8'h01, 1);
      for (int i = 0; i < 9; i++) step(1, 0, 8'h00, 1);
      step(1, 1, 8'h80, 1);
      for (int i = 0; i < 11; i++) step(1, 0, 8'h00, 1);
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 59) != 0, $urandom_range(0, 3) == 0, W'($urandom), $urandom_range(0, 1) == 1);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
